// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, rates and load-stage state encoding for the SHAKE core
package keccak_pkg;

    localparam int w                    = 64;
    localparam int RATE_SHAKE128        = 1344;
    localparam int RATE_SHAKE256        = 1088;
    localparam logic SHAKE256_MODE_VEC  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PAD,
        HANDOFF
    } load_state_t;

    // Number of w-bit words in one rate block for the given mode bit.
    function automatic int rate_words(input logic mode);
        return ((mode == SHAKE256_MODE_VEC) ? RATE_SHAKE256 : RATE_SHAKE128) / w;
    endfunction

endpackage

// File: rtl/load_controller.sv
// load_controller: sequences header/data loading, padding and block handoff
// for one SHAKE message at a time.
module load_controller
    import keccak_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic ready_o,
    input  logic input_buffer_full,
    input  logic input_size_reached,
    input  logic first_incomplete_input_word,
    input  logic last_input_block,
    output logic control_regs_enable,
    output logic load_enable,
    output logic padding_enable,
    output logic padding_reset,
    output logic input_counter_en,
    output logic input_counter_load,
    output logic block_valid_o,
    input  logic block_ready_i,
    output logic last_block_o,
    output logic busy_o
);

    load_state_t state_q, state_d;
    logic        last_q, last_d;
    logic        rst_q;
    logic        live;
    logic        accept;
    logic        pad_load;
    logic        handoff;

    // Outputs stay quiet while reset is applied and for the cycle after it.
    always_comb begin
        live                = !rst && !rst_q;
        ready_o             = live && ((state_q == IDLE) ||
                              (state_q == LOAD && !input_buffer_full && !input_size_reached));
        accept              = valid_i && ready_o;
        pad_load            = live && state_q == PAD && !input_buffer_full;
        handoff             = live && state_q == HANDOFF && block_ready_i;
        control_regs_enable = accept && state_q == IDLE;
        padding_reset       = accept && state_q == IDLE;
        load_enable         = (accept && state_q == LOAD) || pad_load;
        input_counter_en    = load_enable;
        padding_enable      = (accept && state_q == LOAD && first_incomplete_input_word) || pad_load;
        input_counter_load  = (accept && state_q == IDLE) || (handoff && !last_q);
        block_valid_o       = live && state_q == HANDOFF;
        last_block_o        = block_valid_o && last_q;
        busy_o              = live && state_q != IDLE;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE:    state_d = accept ? LOAD : IDLE;
            LOAD: begin
                if (input_buffer_full) begin
                    state_d = HANDOFF;
                    last_d  = last_input_block;
                end else if (input_size_reached) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                if (input_buffer_full) begin
                    state_d = HANDOFF;
                    last_d  = last_input_block;
                end
            end
            HANDOFF: begin
                if (handoff)
                    state_d = last_q ? IDLE : (input_size_reached ? PAD : LOAD);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_load_controller.sv
// tb_load_controller: closed-loop bench; a datapath stand-in feeds status back,
// and per-cycle expectations come from a message-level trace generator.
module tb_load_controller;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_i = 1'b0;
    logic block_ready_i = 1'b0;
    logic ready_o, control_regs_enable, load_enable, padding_enable, padding_reset;
    logic input_counter_en, input_counter_load, block_valid_o, last_block_o, busy_o;
    logic input_buffer_full, input_size_reached, first_incomplete_input_word, last_input_block;

    always #5 clk = ~clk;

    load_controller dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .input_buffer_full(input_buffer_full), .input_size_reached(input_size_reached),
        .first_incomplete_input_word(first_incomplete_input_word),
        .last_input_block(last_input_block), .control_regs_enable(control_regs_enable),
        .load_enable(load_enable), .padding_enable(padding_enable),
        .padding_reset(padding_reset), .input_counter_en(input_counter_en),
        .input_counter_load(input_counter_load), .block_valid_o(block_valid_o),
        .block_ready_i(block_ready_i), .last_block_o(last_block_o), .busy_o(busy_o)
    );

    localparam logic [9:0] RDY = 10'h200, CRE = 10'h100, LE = 10'h080, PE = 10'h040;
    localparam logic [9:0] PR = 10'h020, ICE = 10'h010, ICL = 10'h008, BV = 10'h004;
    localparam logic [9:0] LB = 10'h002, BSY = 10'h001;

    int msg_r = 21;
    int msg_nb = 1;
    int msg_size = 0;
    int fill = 0;
    int rem = 0;
    int blk = 0;

    always @(posedge clk) begin
        if (control_regs_enable) begin
            rem  <= msg_size;
            fill <= 0;
            blk  <= 0;
        end else begin
            if (input_counter_load) begin
                fill <= 0;
                blk  <= blk + 1;
            end else if (input_counter_en) begin
                fill <= fill + 1;
            end
            if (load_enable) rem <= (rem > w) ? rem - w : 0;
        end
    end

    assign input_buffer_full           = fill >= msg_r;
    assign input_size_reached          = rem == 0;
    assign first_incomplete_input_word = rem > 0 && rem < w;
    assign last_input_block            = blk == msg_nb - 1;

    typedef struct packed {
        logic       v;
        logic       br;
        logic       r;
        logic [9:0] e;
    } item_t;

    item_t      tr[$];
    logic [9:0] cur_exp = '0;
    bit         started = 0;
    bit         done = 0;
    string      lit_name[$];
    int         lit_kind[$];
    int         lit_exp[$];

    function automatic item_t mk(input logic v, input logic br, input logic r, input logic [9:0] e);
        mk = '{v: v, br: br, r: r, e: e};
    endfunction

    // Expected cycle trace of one message with valid_i always offered and
    // block_ready_i raised after dly waiting cycles in every handoff.
    task automatic build(input int rw, input int size, input int dly);
        int  words = (size + w - 1) / w;
        int  nb = size / (w * rw) + 1;
        int  wi = 0;
        int  n;
        bit  in_pad = 0;
        bit  last;
        tr.push_back(mk(1, 0, 0, RDY | CRE | PR | ICL));
        for (int b = 0; b < nb; b++) begin
            n = 0;
            last = (b == nb - 1);
            if (!in_pad) begin
                while (n < rw && wi < words) begin
                    tr.push_back(mk(1, 0, 0, RDY | LE | ICE | BSY |
                        ((wi == words - 1 && size % w != 0) ? PE : 10'h0)));
                    n++;
                    wi++;
                end
                if (n < rw) tr.push_back(mk(1, 0, 0, BSY));
            end
            for (; n < rw; n++) tr.push_back(mk(1, 0, 0, LE | ICE | PE | BSY));
            tr.push_back(mk(1, 0, 0, BSY));
            for (int d = 0; d < dly; d++) tr.push_back(mk(0, 0, 0, BV | BSY | (last ? LB : 10'h0)));
            tr.push_back(mk(0, 1, 0, BV | BSY | (last ? LB : ICL)));
            in_pad = (wi == words);
        end
        tr.push_back(mk(0, 0, 0, RDY));
    endtask

    task automatic play(input int n);
        for (int i = 0; i < tr.size() && (n < 0 || i < n); i++) begin
            @(posedge clk);
            #1;
            rst           = tr[i].r;
            valid_i       = tr[i].v;
            block_ready_i = tr[i].br;
            cur_exp       = tr[i].e;
            started       = 1;
        end
        tr.delete();
    endtask

    task automatic run_msg(input int rw, input int size, input int dly);
        msg_r    = rw;
        msg_nb   = size / (w * rw) + 1;
        msg_size = size;
        build(rw, size, dly);
        play(-1);
    endtask

    task automatic lit(input string nm, input int kind, input int e);
        lit_name.push_back(nm);
        lit_kind.push_back(kind);
        lit_exp.push_back(e);
    endtask

    initial begin
        int r128, r256;
        r128 = rate_words(1'b0);
        r256 = rate_words(1'b1);
        tr.push_back(mk(0, 0, 1, 10'h0));
        tr.push_back(mk(0, 0, 1, 10'h0));
        tr.push_back(mk(0, 0, 0, 10'h0));
        tr.push_back(mk(0, 0, 0, RDY));
        play(-1);
        run_msg(r128, 64, 3);
        lit("t1_loads", 0, 21); lit("t1_pads", 1, 20); lit("t1_valid", 2, 4); lit("t1_last", 3, 4);
        run_msg(r256, 1088, 0);
        lit("t2_loads", 0, 34); lit("t2_pads", 1, 17); lit("t2_valid", 2, 2); lit("t2_last", 3, 1);
        run_msg(r128, 40, 0);
        lit("t3_loads", 0, 21); lit("t3_pads", 1, 21);
        run_msg(r128, 0, 1);
        lit("t4_loads", 0, 21); lit("t4_pads", 1, 21); lit("t4_accepts", 4, 0); lit("t4_last", 3, 2);
        run_msg(r128, 64, 10);
        lit("t5_valid", 2, 11); lit("t5_quiet", 5, 0);
        msg_r = r128;
        msg_nb = 3;
        msg_size = 2688;
        build(r128, 2688, 0);
        play(8);
        tr.push_back(mk(1, 0, 1, 10'h0));
        tr.push_back(mk(0, 0, 0, 10'h0));
        tr.push_back(mk(0, 0, 0, RDY));
        play(-1);
        lit("t6_loads", 0, 7);
        run_msg(r256, 1600, 2);
        lit("t6_next_loads", 0, 34); lit("t6_next_pads", 1, 9); lit("t6_next_valid", 2, 6);
        @(posedge clk);
        #1;
        done = 1;
    end

    initial begin
        int total = 0, bad = 0, cyc = 0, act_v;
        int n_le = 0, n_pe = 0, n_bv = 0, n_lb = 0, n_acc = 0, n_act = 0;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            if (started) begin
                act = {ready_o, control_regs_enable, load_enable, padding_enable, padding_reset,
                       input_counter_en, input_counter_load, block_valid_o, last_block_o, busy_o};
                total++;
                if (act !== cur_exp) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%b want=%b", cyc, act, cur_exp);
                end
                n_le  += int'(load_enable);
                n_pe  += int'(load_enable && padding_enable);
                n_bv  += int'(block_valid_o);
                n_lb  += int'(block_valid_o && last_block_o);
                n_acc += int'(busy_o && valid_i && ready_o);
                n_act += int'(block_valid_o && (ready_o || load_enable || input_counter_en || input_counter_load));
                if (lit_name.size() > 0) begin
                    while (lit_name.size() > 0) begin
                        case (lit_kind[0])
                            0: act_v = n_le;
                            1: act_v = n_pe;
                            2: act_v = n_bv;
                            3: act_v = n_lb;
                            4: act_v = n_acc;
                            default: act_v = n_act;
                        endcase
                        total++;
                        if (act_v != lit_exp[0]) begin
                            bad++;
                            $display("FAIL %s got=%0d want=%0d", lit_name[0], act_v, lit_exp[0]);
                        end
                        void'(lit_name.pop_front());
                        void'(lit_kind.pop_front());
                        void'(lit_exp.pop_front());
                    end
                    n_le = 0; n_pe = 0; n_bv = 0; n_lb = 0; n_acc = 0; n_act = 0;
                end
            end
            if (cyc > 50000) begin
                bad++;
                $display("FAIL timeout cyc=%0d", cyc);
            end
            if (done || cyc > 50000) begin
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule
